processing_hw_prod_accum: RTL



---
 rtl/processing_hw_prod_accum_if.sv | 27 ++
 rtl/processing_hw_prod_accum.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/processing_hw_prod_accum_if.sv
// Product-stream / result-stream bundle between the multiplier pipeline,
// the frame accumulator and its downstream consumer.
interface processing_hw_prod_accum_if #(
  parameter int PROD_WIDTH = 27,
  parameter int OUT_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic [PROD_WIDTH-1:0] din;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  dout;
  logic                  out_sat;
  logic [CNT_WIDTH-1:0]  out_count;

  modport master (
    output in_valid, din, in_last, out_ready,
    input  in_ready, out_valid, dout, out_sat, out_count
  );

  modport slave (
    input  in_valid, din, in_last, out_ready,
    output in_ready, out_valid, dout, out_sat, out_count
  );
endinterface

// File: rtl/processing_hw_prod_accum.sv
// Frame accumulator for the 13x14 multiplier product stream. Sums the beats
// of a frame (delimited by in_last) with saturation, then rounds half-up,
// drops SHIFT fraction bits and clips to OUT_WIDTH. The result sits in a
// one-entry output register; in_ready doubles as the upstream multiplier ce.
module processing_hw_prod_accum #(
  parameter int PROD_WIDTH = 27,
  parameter int ACC_WIDTH  = 36,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 11,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce,
  processing_hw_prod_accum_if.slave      bus
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [ACC_WIDTH:0] HALF    = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [ACC_WIDTH:0] OUT_MAX = {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  // Unsigned add with clamp at all-ones; MSB of the return value flags the clamp.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0]  a,
                                                 input logic [PROD_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] w;
    w = {1'b0, a} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, b};
    if (w[ACC_WIDTH]) sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
    else              sat_add = w;
  endfunction

  // Round half up, then drop the fraction bits; one guard bit avoids wrap.
  function automatic logic [ACC_WIDTH:0] round_shift(input logic [ACC_WIDTH-1:0] s);
    logic [ACC_WIDTH:0] w;
    w = {1'b0, s} + HALF;
    round_shift = w >> SHIFT;
  endfunction

  // Clip to the output word; MSB of the return value flags the clip.
  function automatic logic [OUT_WIDTH:0] clip_out(input logic [ACC_WIDTH:0] r);
    if (r > OUT_MAX) clip_out = {1'b1, {OUT_WIDTH{1'b1}}};
    else             clip_out = {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  // Beat counter that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) cnt_inc = c;
    else    cnt_inc = c + CNT_WIDTH'(1);
  endfunction

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   ovf_q;
  logic                   out_valid_q;
  logic [OUT_WIDTH-1:0]   dout_q;
  logic                   out_sat_q;
  logic [CNT_WIDTH-1:0]   out_count_q;

  logic                   in_ready;
  logic                   accept;
  logic                   xfer;
  logic                   ld_frame;
  logic                   ld_result;

  logic [ACC_WIDTH-1:0]   base;
  logic [ACC_WIDTH:0]     add_w;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   ovf_next;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [ACC_WIDTH:0]     rnd;
  logic [OUT_WIDTH:0]     clip_w;

  // Back-pressure only when a result is held and downstream refuses it.
  assign in_ready  = !(out_valid_q && !bus.out_ready);
  assign accept    = ce && bus.in_valid && in_ready;
  assign xfer      = ce && out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_count = out_count_q;

  // Next sum, overflow flag, count and rounded/clipped word for the current beat.
  always_comb begin
    base     = (state_q == IDLE) ? '0 : acc_q;
    add_w    = sat_add(base, bus.din);
    sum      = add_w[ACC_WIDTH-1:0];
    ovf_next = ((state_q == ACCUM) && ovf_q) || add_w[ACC_WIDTH];
    cnt_next = (state_q == IDLE) ? CNT_WIDTH'(1) : cnt_inc(cnt_q);
    rnd      = round_shift(sum);
    clip_w   = clip_out(rnd);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a non-last beat opens or extends a frame, a last beat closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bus.in_last) state_d = ACCUM;
      ACCUM:   if (accept &&  bus.in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load strobes for the partial-sum and result registers.
  always_comb begin
    ld_frame  = 1'b0;
    ld_result = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        ld_frame  = accept && !bus.in_last;
        ld_result = accept &&  bus.in_last;
      end
      default: ;
    endcase
  end

  // Partial-frame registers; cleared when a frame closes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (ld_result) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (ld_frame) begin
      acc_q <= sum;
      cnt_q <= cnt_next;
      ovf_q <= ovf_next;
    end
  end

  // One-entry result buffer; a new result may replace one leaving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else if (ld_result) begin
      out_valid_q <= 1'b1;
      dout_q      <= clip_w[OUT_WIDTH-1:0];
      out_sat_q   <= ovf_next || clip_w[OUT_WIDTH];
      out_count_q <= cnt_next;
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
